// File: rtl/lfsr_burst_scheduler.sv
// Round-robin burst scheduler sharing one lfsr_32 source between NUM_REQ requesters.
// Words stream on a valid/ready port tagged with the requester id; the LFSR steps only on accepted words.
module lfsr_burst_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int LEN_WIDTH = 16,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          lfsr_enable,
  input  logic [31:0]                   lfsr_value,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [31:0]                   m_data,
  output logic                          m_last,
  output logic [ID_WIDTH-1:0]           m_id
);

  // state | meaning
  // IDLE  | arbitrate among pending requests, latch length of the winner
  // BURST | stream words; remaining counts down per accepted word
  // DONE  | one-cycle done pulse for the finished requester
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                state, state_n;
  logic [ID_WIDTH-1:0]   id_q, id_n;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_n;
  logic [ID_WIDTH-1:0]   sel;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  found;
  logic                  xfer;

  // First pending request at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

  assign sel_len = req_len[int'(sel)*LEN_WIDTH +: LEN_WIDTH];

  assign m_valid     = (state == BURST);
  assign m_last      = m_valid && (remaining == LEN_WIDTH'(1));
  assign m_data      = lfsr_value;
  assign m_id        = id_q;
  assign xfer        = m_valid && m_ready;
  assign lfsr_enable = xfer;
  assign gnt         = (state == BURST) ? (NUM_REQ'(1) << id_q) : '0;
  assign done        = (state == DONE)  ? (NUM_REQ'(1) << id_q) : '0;

  always_comb begin
    state_n     = state;
    id_n        = id_q;
    rr_n        = rr_ptr;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        if (found) begin
          id_n        = sel;
          remaining_n = sel_len;
          rr_n        = (sel == ID_WIDTH'(NUM_REQ-1)) ? '0 : sel + 1'b1;
          state_n     = (sel_len != '0) ? BURST : DONE;
        end
      end
      BURST: begin
        if (xfer) begin
          remaining_n = remaining - 1'b1;
          if (m_last) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      id_q      <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      id_q      <= id_n;
      rr_ptr    <= rr_n;
      remaining <= remaining_n;
    end
  end

endmodule

// File: tb/tb_lfsr_burst_scheduler.sv
// Directed bench for lfsr_burst_scheduler; the random source is a counter model so words are predictable.
module tb_lfsr_burst_scheduler;

  localparam int NR = 4;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic            lfsr_enable;
  logic [31:0]     lfsr_value;
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     m_data;
  logic            m_last;
  logic [1:0]      m_id;
  logic            lfsr_rst;

  int total = 0;
  int bad   = 0;

  lfsr_burst_scheduler #(.NUM_REQ(NR), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt), .done(done),
    .lfsr_enable(lfsr_enable), .lfsr_value(lfsr_value), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_id(m_id)
  );

  always #5 clk = ~clk;

  // Stand-in source: steps by one per enable, so expected words are 0,1,2,...
  always @(posedge clk) begin
    if (lfsr_rst) lfsr_value <= 32'd0;
    else if (lfsr_enable) lfsr_value <= lfsr_value + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reseed();
    lfsr_rst = 1'b1;
    tick();
    lfsr_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_len = '0; m_ready = 1'b1; lfsr_rst = 1'b1;
    tick(); tick();
    lfsr_rst = 1'b0;
    #1;
    total++; if (gnt !== 4'b0)  begin bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done got %b want 0000", done); end
    total++; if ({m_valid, m_last, lfsr_enable} !== 3'b000)
      begin bad++; $display("FAIL reset_valid_last_en got %b want 000", {m_valid, m_last, lfsr_enable}); end
    total++; if (m_id !== 2'd0) begin bad++; $display("FAIL reset_id got %0d want 0", m_id); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    reseed();
    req = 4'b0001; req_len[0*LW +: LW] = 16'd3; m_ready = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL basic_gnt_early got %b want 0000", gnt); end
    tick();
    req = '0;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL basic_gnt got %b want 0001", gnt); end
    for (int i = 0; i < 3; i++) begin
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid w%0d got %b want 1", i, m_valid); end
      total++; if (m_data !== 32'(i)) begin bad++; $display("FAIL basic_data w%0d got %h want %h", i, m_data, 32'(i)); end
      total++; if (m_last !== (i == 2)) begin bad++; $display("FAIL basic_last w%0d got %b want %b", i, m_last, i == 2); end
      total++; if (lfsr_enable !== 1'b1) begin bad++; $display("FAIL basic_en w%0d got %b want 1", i, lfsr_enable); end
      tick();
    end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL basic_done got %b want 0001", done); end
    total++; if ({m_valid, gnt} !== 5'b0) begin bad++; $display("FAIL basic_idle_after got %b want 00000", {m_valid, gnt}); end
    tick();
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL basic_done_width got %b want 0000", done); end
  endtask

  task automatic test_backpressure();
    reseed();
    req = 4'b0001; req_len[0*LW +: LW] = 16'd3; m_ready = 1'b1;
    tick();
    req = '0;
    total++; if (m_data !== 32'd0) begin bad++; $display("FAIL bp_w0 got %h want 0", m_data); end
    tick();
    for (int c = 2; c <= 4; c++) begin
      m_ready = 1'b0;
      #1;
      total++; if (m_data !== 32'd1) begin bad++; $display("FAIL bp_hold c%0d got %h want 1", c, m_data); end
      total++; if (lfsr_enable !== 1'b0) begin bad++; $display("FAIL bp_en c%0d got %b want 0", c, lfsr_enable); end
      total++; if ({m_valid, m_last} !== 2'b10) begin bad++; $display("FAIL bp_vl c%0d got %b want 10", c, {m_valid, m_last}); end
      tick();
    end
    m_ready = 1'b1;
    #1;
    total++; if (m_data !== 32'd1 || lfsr_enable !== 1'b1)
      begin bad++; $display("FAIL bp_resume got %h/%b want 1/1", m_data, lfsr_enable); end
    tick();
    total++; if (m_data !== 32'd2 || m_last !== 1'b1)
      begin bad++; $display("FAIL bp_last got %h/%b want 2/1", m_data, m_last); end
    tick();
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL bp_done got %b want 0001", done); end
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    reseed();
    m_ready = 1'b1;
    for (int i = 0; i < NR; i++) req_len[i*LW +: LW] = 16'd1;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (gnt !== (4'b0001 << (k % 4)))
        begin bad++; $display("FAIL rr_gnt k%0d got %b want %b", k, gnt, 4'b0001 << (k % 4)); end
      total++; if (m_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id k%0d got %0d want %0d", k, m_id, k % 4); end
      total++; if (m_data !== 32'(k) || m_last !== 1'b1)
        begin bad++; $display("FAIL rr_word k%0d got %h/%b want %h/1", k, m_data, m_last, 32'(k)); end
      if (k == 4) req = '0;
      tick();
      total++; if (done !== (4'b0001 << (k % 4)))
        begin bad++; $display("FAIL rr_done k%0d got %b want %b", k, done, 4'b0001 << (k % 4)); end
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rr_gap k%0d got %b want 0", k, m_valid); end
      tick();
    end
  endtask

  task automatic test_zero_length();
    logic [31:0] v;
    v = lfsr_value;
    req = 4'b0010; req_len[1*LW +: LW] = 16'd0;
    tick();
    req = '0;
    total++; if (m_valid !== 1'b0 || gnt !== 4'b0)
      begin bad++; $display("FAIL zl_valid got %b/%b want 0/0000", m_valid, gnt); end
    total++; if (done !== 4'b0010) begin bad++; $display("FAIL zl_done got %b want 0010", done); end
    tick();
    total++; if (m_valid !== 1'b0 || done !== 4'b0)
      begin bad++; $display("FAIL zl_after got %b/%b want 0/0000", m_valid, done); end
    total++; if (lfsr_value !== v) begin bad++; $display("FAIL zl_lfsr got %h want %h", lfsr_value, v); end
  endtask

  task automatic test_req_drop();
    logic [31:0] v;
    v = lfsr_value;
    req = 4'b0001; req_len[0*LW +: LW] = 16'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (m_valid !== 1'b1 || m_data !== v + 32'(i) || m_last !== (i == 4))
        begin bad++; $display("FAIL drop_w%0d got %b/%h/%b want 1/%h/%b", i, m_valid, m_data, m_last, v + 32'(i), i == 4); end
      if (i == 1) begin req = '0; req_len[0*LW +: LW] = 16'd1; end
      tick();
    end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL drop_done got %b want 0001", done); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001; req_len[0*LW +: LW] = 16'd4;
    tick();
    req = '0;
    tick();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL rmb_pre got %b want 1", m_valid); end
    rst = 1'b1;
    #1;
    total++; if ({m_valid, lfsr_enable} !== 2'b00 || gnt !== 4'b0 || done !== 4'b0)
      begin bad++; $display("FAIL rmb_clear got %b/%b/%b/%b want 0/0/0000/0000", m_valid, lfsr_enable, gnt, done); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (done !== 4'b0) begin bad++; $display("FAIL rmb_nodone got %b want 0000", done); end
    req = 4'b0100; req_len[2*LW +: LW] = 16'd1;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0100 || m_id !== 2'd2)
      begin bad++; $display("FAIL rmb_gnt got %b/%0d want 0100/2", gnt, m_id); end
    tick();
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL rmb_done got %b want 0100", done); end
    // Pointer now at 3: with 0 and 3 pending, 3 wins.
    req = 4'b1001; req_len[0*LW +: LW] = 16'd1; req_len[3*LW +: LW] = 16'd1;
    tick();
    tick();
    req = '0;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rmb_ptr got %b want 1000", gnt); end
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_round_robin();
    test_zero_length();
    test_req_drop();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
